// File: rtl/multiword_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multiword_adder_pkg;

    // Controller states: IDLE waits for start, RUN processes one chunk per cycle.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default geometry: 4 chunks of 4 bits.
    localparam int DEF_W   = 4;
    localparam int DEF_N   = 4;
    localparam int TOTAL_W = DEF_W * DEF_N;

    // Chunk index width; a single-chunk adder still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Full operand width for a given chunk geometry.
    function automatic int total_width(input int w, input int n);
        return w * n;
    endfunction

endpackage

// File: rtl/cla_slice.sv
// W-bit carry lookahead slice: every carry is formed directly from g, p and cin.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_g/i_p per-bit generate/propagate, i_cin carry in, o_c carry out of each bit.
module cla_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_g,
    input  logic [W-1:0] i_p,
    input  logic         i_cin,
    output logic [W-1:0] o_c
);

    logic w_term;
    logic w_prop;

    // c[i] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, built as a flat sum of
    // products per bit rather than a ripple through c[i-1].
    always_comb begin
        o_c    = '0;
        w_term = 1'b0;
        w_prop = 1'b1;
        for (int i = 0; i < W; i++) begin
            w_term = 1'b0;
            w_prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_term = w_term | (i_g[j] & w_prop);
                w_prop = w_prop & i_p[j];
            end
            o_c[i] = w_term | (w_prop & i_cin);
        end
    end

endmodule

// File: rtl/multiword_adder_gp_gen.sv
// Per-bit generate/propagate terms for one W-bit operand chunk.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
// Ports: i_a_chunk/i_b_chunk operand chunk bits; o_g generate, o_p propagate.
module gp_gen #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a_chunk,
    input  logic [W-1:0] i_b_chunk,
    output logic [W-1:0] o_g,
    output logic [W-1:0] o_p
);

    assign o_g = i_a_chunk & i_b_chunk;
    assign o_p = i_a_chunk ^ i_b_chunk;

endmodule

// File: rtl/multiword_adder.sv
// Adds two N*W-bit operands one W-bit chunk per cycle, carry chained through a register.
// Latency: N RUN cycles after the accepted start, then a one-cycle done pulse (N+1 per result).
// Backpressure: start is only honoured in IDLE; starts while busy are dropped, not queued.
// Ports: i_clk/i_rst (sync, active-high); i_start, i_a, i_b, i_cin request;
//        o_busy while running, o_done pulse, o_sum/o_cout result held until next start.
module multiword_adder
    import multiword_adder_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    input  logic [W*N-1:0] i_a,
    input  logic [W*N-1:0] i_b,
    input  logic           i_cin,
    output logic           o_busy,
    output logic           o_done,
    output logic [W*N-1:0] o_sum,
    output logic           o_cout
);

    localparam int                SUM_W    = total_width(W, N);
    localparam int                IDX_W    = idx_width(N);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);

    state_t             r_state;
    logic [SUM_W-1:0]   r_a;
    logic [SUM_W-1:0]   r_b;
    logic [SUM_W-1:0]   r_sum;
    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic               r_cout;
    logic               r_done;

    logic [31:0]        w_base;
    logic [W-1:0]       w_a_chunk;
    logic [W-1:0]       w_b_chunk;
    logic [W-1:0]       w_g;
    logic [W-1:0]       w_p;
    logic [W-1:0]       w_c;
    logic [W:0]         w_cin_vec;
    logic [W-1:0]       w_sum_chunk;

    assign w_base    = 32'(r_idx) * 32'(W);
    assign w_a_chunk = r_a[w_base +: W];
    assign w_b_chunk = r_b[w_base +: W];

    gp_gen #(.W(W)) u_gp_gen (
        .i_a_chunk (w_a_chunk),
        .i_b_chunk (w_b_chunk),
        .o_g       (w_g),
        .o_p       (w_p)
    );

    cla_slice #(.W(W)) u_cla_slice (
        .i_g   (w_g),
        .i_p   (w_p),
        .i_cin (r_carry),
        .o_c   (w_c)
    );

    // Carry into each bit: bit 0 takes the chained carry register, bit i takes c[i-1].
    // Building it as {c, carry} and dropping the top bit keeps W=1 legal.
    assign w_cin_vec   = {w_c, r_carry};
    assign w_sum_chunk = w_p ^ w_cin_vec[W-1:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= i_a;
                        r_b     <= i_b;
                        r_carry <= i_cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[w_base +: W] <= w_sum_chunk;
                    r_carry            <= w_c[W-1];
                    if (r_idx == LAST_IDX) begin
                        // Index returns to 0 rather than stepping past N-1.
                        r_cout  <= w_c[W-1];
                        r_done  <= 1'b1;
                        r_idx   <= '0;
                        r_state <= IDLE;
                    end else begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == RUN);
    assign o_done = r_done;
    assign o_sum  = r_sum;
    assign o_cout = r_cout;

endmodule

// File: tb/tb_multiword_adder.sv
module tb_multiword_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DUT0: W=4, N=4
    logic        start0, cin0, busy0, done0, cout0;
    logic [15:0] a0, b0, sum0;
    // DUT1: W=4, N=1
    logic        start1, cin1, busy1, done1, cout1;
    logic [3:0]  a1, b1, sum1;
    // DUT2: W=1, N=8
    logic        start2, cin2, busy2, done2, cout2;
    logic [7:0]  a2, b2, sum2;

    logic [16:0] q0[$];
    logic [4:0]  q1[$];
    logic [8:0]  q2[$];

    multiword_adder #(.W(4), .N(4)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .i_a(a0), .i_b(b0), .i_cin(cin0),
        .o_busy(busy0), .o_done(done0), .o_sum(sum0), .o_cout(cout0)
    );
    multiword_adder #(.W(4), .N(1)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_start(start1), .i_a(a1), .i_b(b1), .i_cin(cin1),
        .o_busy(busy1), .o_done(done1), .o_sum(sum1), .o_cout(cout1)
    );
    multiword_adder #(.W(1), .N(8)) u_dut2 (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_a(a2), .i_b(b2), .i_cin(cin2),
        .o_busy(busy2), .o_done(done2), .o_sum(sum2), .o_cout(cout2)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] exp0(input logic [15:0] a, input logic [15:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {16'd0, c};
    endfunction
    function automatic logic [4:0] exp1(input logic [3:0] a, input logic [3:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {4'd0, c};
    endfunction
    function automatic logic [8:0] exp2(input logic [7:0] a, input logic [7:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {8'd0, c};
    endfunction

    // Scoreboard monitors: every done pulse pops one expected {cout,sum}.
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            logic [16:0] e0;
            if (q0.size() == 0) chk("d0_unexpected_done", {63'd0, done0}, 64'd0);
            else begin
                e0 = q0.pop_front();
                chk("d0_result", {cout0, sum0}, e0);
            end
            chk("d0_busy_in_done", busy0, 0);
        end
    end
    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            logic [4:0] e1;
            if (q1.size() == 0) chk("d1_unexpected_done", {63'd0, done1}, 64'd0);
            else begin
                e1 = q1.pop_front();
                chk("d1_result", {cout1, sum1}, e1);
            end
            chk("d1_busy_in_done", busy1, 0);
        end
    end
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            logic [8:0] e2;
            if (q2.size() == 0) chk("d2_unexpected_done", {63'd0, done2}, 64'd0);
            else begin
                e2 = q2.pop_front();
                chk("d2_result", {cout2, sum2}, e2);
            end
            chk("d2_busy_in_done", busy2, 0);
        end
    end

    // One complete DUT0 operation with exact timing checks; called at a negedge while idle.
    task automatic op0(input logic [15:0] a, input logic [15:0] b, input logic c);
        logic [16:0] e;
        e = exp0(a, b, c);
        start0 = 1'b1; a0 = a; b0 = b; cin0 = c;
        q0.push_back(e);
        @(negedge clk);
        start0 = 1'b0;
        a0 = 16'h5A5A; b0 = 16'hA5A5; cin0 = ~c;
        for (int i = 0; i < 4; i++) begin
            chk("d0_busy", busy0, 1);
            chk("d0_done_early", done0, 0);
            @(negedge clk);
        end
        chk("d0_done", done0, 1);
        chk("d0_busy_clr", busy0, 0);
        @(negedge clk);
        chk("d0_done_one_cycle", done0, 0);
        chk("d0_hold", {cout0, sum0}, e);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gap;
        int pulses;
        rst = 1'b1;
        start0 = 0; a0 = '0; b0 = '0; cin0 = 0;
        start1 = 0; a1 = '0; b1 = '0; cin1 = 0;
        start2 = 0; a2 = '0; b2 = '0; cin2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy0", busy0, 0);
        chk("rst_done0", done0, 0);
        chk("rst_sum0", sum0, 0);
        chk("rst_cout0", cout0, 0);
        chk("rst_busy2", busy2, 0);
        chk("rst_sum1", {cout1, sum1}, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed operations
        op0(16'hFFFF, 16'h0001, 1'b0);
        op0(16'h1234, 16'h4321, 1'b1);
        op0(16'h00FF, 16'h0001, 1'b0);

        // Start pulsed during busy with other operands must be ignored.
        start0 = 1'b1; a0 = 16'h1234; b0 = 16'h4321; cin0 = 1'b1;
        q0.push_back(exp0(16'h1234, 16'h4321, 1'b1));
        @(negedge clk); start0 = 1'b0;
        @(negedge clk); start0 = 1'b1; a0 = 16'hAAAA; b0 = 16'h5555; cin0 = 1'b1;
        @(negedge clk); start0 = 1'b0; a0 = 16'h0F0F; b0 = 16'hF0F0;
        @(negedge clk);
        @(negedge clk);
        chk("ign_done", done0, 1);
        chk("ign_sum", {cout0, sum0}, 17'h05556);
        @(negedge clk);
        chk("ign_not_queued", busy0, 0);

        // Start held high through the done cycle: back-to-back acceptance.
        start0 = 1'b1; a0 = 16'h00FF; b0 = 16'h0001; cin0 = 1'b0;
        q0.push_back(exp0(16'h00FF, 16'h0001, 1'b0));
        @(negedge clk);
        a0 = 16'h8000; b0 = 16'h8000; cin0 = 1'b0;
        q0.push_back(exp0(16'h8000, 16'h8000, 1'b0));
        gap = 1;
        while (done0 !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b_first_latency", gap, 5);
        @(negedge clk);
        start0 = 1'b0;
        gap = 1;
        while (done0 !== 1'b1 && gap < 20) begin @(negedge clk); gap++; end
        chk("b2b_gap", gap, 5);
        chk("b2b_sum", {cout0, sum0}, 17'h10000);
        @(negedge clk);

        // Reset two cycles into RUN aborts with no done pulse.
        start0 = 1'b1; a0 = 16'hFFFF; b0 = 16'hFFFF; cin0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy0, 0);
        chk("abort_done", done0, 0);
        chk("abort_sum", sum0, 0);
        chk("abort_cout", cout0, 0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done0 === 1'b1) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        op0(16'hBEEF, 16'h1111, 1'b0);

        // Random operations on all three geometries in parallel, back-to-back.
        fork
            begin
                for (int n = 0; n < 1000; n++) begin
                    logic [15:0] ra, rb;
                    logic        rc;
                    int          t;
                    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1));
                    start0 = 1'b1; a0 = ra; b0 = rb; cin0 = rc;
                    q0.push_back(exp0(ra, rb, rc));
                    @(negedge clk);
                    start0 = 1'b0; a0 = 16'($urandom); b0 = 16'($urandom);
                    t = 1;
                    while (done0 !== 1'b1 && t < 12) begin @(negedge clk); t++; end
                    chk("d0_latency", t, 5);
                end
            end
            begin
                for (int n = 0; n < 1000; n++) begin
                    logic [3:0] ra, rb;
                    logic       rc;
                    int         t;
                    ra = 4'($urandom); rb = 4'($urandom); rc = 1'($urandom_range(0, 1));
                    start1 = 1'b1; a1 = ra; b1 = rb; cin1 = rc;
                    q1.push_back(exp1(ra, rb, rc));
                    @(negedge clk);
                    start1 = 1'b0; a1 = 4'($urandom); b1 = 4'($urandom);
                    t = 1;
                    while (done1 !== 1'b1 && t < 12) begin @(negedge clk); t++; end
                    chk("d1_latency", t, 2);
                end
            end
            begin
                for (int n = 0; n < 1000; n++) begin
                    logic [7:0] ra, rb;
                    logic       rc;
                    int         t;
                    ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom_range(0, 1));
                    start2 = 1'b1; a2 = ra; b2 = rb; cin2 = rc;
                    q2.push_back(exp2(ra, rb, rc));
                    @(negedge clk);
                    start2 = 1'b0; a2 = 8'($urandom); b2 = 8'($urandom);
                    t = 1;
                    while (done2 !== 1'b1 && t < 16) begin @(negedge clk); t++; end
                    chk("d2_latency", t, 9);
                end
            end
        join
        start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
